uart_rx: RTL and testbench

Serial-to-parallel UART receiver, placed directly upstream of the UART scoreboard. It synchronises the asynchronous serial line and detects 8N1 frames (1 start bit, 8 data bits LSB-first, no parity, 1 stop bit) using a bit-period counter. It presents each good byte with a one-cycle valid strobe, and flags frames with a bad stop bit as framing errors.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_if.sv | 13 +
 rtl/uart_sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 116 +++++++++++
 tb/tb_uart_rx.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame-format constants.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bundle: byte, valid/error strobes and busy flag.
interface uart_rx_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] rx_byte;
   logic                      rx_valid;
   logic                      frame_err;
   logic                      busy;

   modport master (output rx_byte, rx_valid, frame_err, busy);
   modport slave  (input  rx_byte, rx_valid, frame_err, busy);

endinterface

// File: rtl/uart_sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit; reset value selectable.
module uart_sync_2ff #(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: non-blocking assignments keep meta and q as two distinct flops; blocking would collapse them into one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VALUE;
         q    <= RESET_VALUE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a bit-period counter, one-cycle valid/framing-error strobes.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     rx_serial,
   uart_rx_if.master rx_if
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(UART_DATA_BITS);
   localparam int H  = CLKS_PER_BIT / 2;

   localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_BITS - 1);

   logic rx_s;

   uart_rx_state_e            state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [UART_DATA_BITS-1:0] byte_q, byte_d;
   logic                      valid_q, valid_d;
   logic                      err_q, err_d;

   uart_sync_2ff #(.RESET_VALUE(UART_IDLE_LEVEL)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_serial),
      .q     (rx_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      // NOTE: every variable gets a default before the case so no branch can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      valid_d = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            // Mid-start check: a high line here was only a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               idx_d          = idx_q + 1'b1;
               if (idx_q == IDX_LAST) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  byte_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = RECOVER;
               end
            end
         end
         RECOVER: begin
            // A held-low break must not look like a fresh start bit.
            cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign rx_if.rx_byte   = byte_q;
   assign rx_if.rx_valid  = valid_q;
   assign rx_if.frame_err = err_q;
   assign rx_if.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: C=16 and C=5 instances, vector table, corner sequences, random frames.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int C16 = 16;
   localparam int C5  = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic ser16 = 1'b1;
   logic ser5  = 1'b1;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_if if16 ();
   uart_rx_if if5 ();

   uart_rx #(.CLKS_PER_BIT(C16)) dut16 (.clk(clk), .rst_n(rst_n), .rx_serial(ser16), .rx_if(if16));
   uart_rx #(.CLKS_PER_BIT(C5))  dut5  (.clk(clk), .rst_n(rst_n), .rx_serial(ser5),  .rx_if(if5));

   typedef struct { int cyc; logic v; logic e; logic [7:0] d; } ev_t;
   typedef struct { int cyc; logic [7:0] d; } exp_t;
   typedef struct { logic [7:0] data; logic stop; logic exp_v; logic [7:0] exp_byte; } vec_t;

   ev_t log16[$];
   ev_t log5[$];

   // Pulses are logged with the cycle number in which they are high (edge index + 1).
   always @(negedge clk) begin
      if (if16.rx_valid || if16.frame_err)
         log16.push_back('{cyc + 1, if16.rx_valid, if16.frame_err, if16.rx_byte});
      if (if5.rx_valid || if5.frame_err)
         log5.push_back('{cyc + 1, if5.rx_valid, if5.frame_err, if5.rx_byte});
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic int cpb(input bit sel);
      return sel ? C5 : C16;
   endfunction

   // Expected strobe cycle for a frame whose start bit is first sampled at edge k.
   function automatic int pulse_at(input bit sel, input int k);
      int c = cpb(sel);
      return k + 3 + c / 2 + 9 * c;
   endfunction

   task automatic set_line(input bit sel, input logic b);
      if (sel) ser5 = b;
      else     ser16 = b;
   endtask

   task automatic hold(input bit sel, input logic b, input int n);
      set_line(sel, b);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop, output int k);
      int c = cpb(sel);
      k = cyc + 1;
      hold(sel, 1'b0, c);
      for (int i = 0; i < 8; i++) hold(sel, d[i], c);
      hold(sel, stop, c);
   endtask

   task automatic settle(input bit sel);
      hold(sel, 1'b1, 2 * cpb(sel) + 4);
   endtask

   task automatic wait_cycle(input int n);
      do @(negedge clk); while (cyc + 1 < n);
   endtask

   task automatic expect_ev(input bit sel, input string name, input int exp_cyc,
                            input logic exp_v, input logic [7:0] exp_d);
      ev_t ev;
      int  n = sel ? log5.size() : log16.size();
      check({name, "_seen"}, 32'(n != 0), 1);
      if (n != 0) begin
         if (sel) ev = log5.pop_front();
         else     ev = log16.pop_front();
         check({name, "_cycle"}, ev.cyc, exp_cyc);
         check({name, "_kind"}, 32'({ev.v, ev.e}), 32'({exp_v, ~exp_v}));
         if (exp_v) check({name, "_byte"}, 32'(ev.d), 32'(exp_d));
      end
   endtask

   task automatic expect_quiet(input bit sel, input string name);
      check(name, sel ? log5.size() : log16.size(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[6];
      exp_t pend[$];
      int   k, k1, k2, k3;

      vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00};
      vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF};
      vecs[2] = '{8'h55, 1'b0, 1'b0, 8'hFF};
      vecs[3] = '{8'hA5, 1'b1, 1'b1, 8'hA5};
      vecs[4] = '{8'h80, 1'b1, 1'b1, 8'h80};
      vecs[5] = '{8'h01, 1'b0, 1'b0, 8'h80};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_byte",  32'(if16.rx_byte), 0);
      check("rst_valid", 32'(if16.rx_valid), 0);
      check("rst_err",   32'(if16.frame_err), 0);
      check("rst_busy",  32'(if16.busy), 0);
      check("rst_busy5", 32'(if5.busy), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      hold(0, 1'b1, 4);

      // Single clean 0x41 frame.
      send_frame(0, 8'h41, 1'b1, k);
      settle(0);
      expect_ev(0, "f41", pulse_at(0, k), 1'b1, 8'h41);
      expect_quiet(0, "f41_only_one");

      // Back-to-back frames with no idle gap.
      send_frame(0, 8'h41, 1'b1, k1);
      send_frame(0, 8'h42, 1'b1, k2);
      send_frame(0, 8'h43, 1'b1, k3);
      settle(0);
      expect_ev(0, "b2b0", pulse_at(0, k1), 1'b1, 8'h41);
      expect_ev(0, "b2b1", pulse_at(0, k2), 1'b1, 8'h42);
      expect_ev(0, "b2b2", pulse_at(0, k3), 1'b1, 8'h43);
      check("b2b_spacing", k3 - k1, 2 * 10 * C16);

      for (int i = 0; i < 6; i++) begin
         send_frame(0, vecs[i].data, vecs[i].stop, k);
         settle(0);
         expect_ev(0, $sformatf("vec%0d", i), pulse_at(0, k), vecs[i].exp_v, vecs[i].exp_byte);
         check($sformatf("vec%0d_held", i), 32'(if16.rx_byte), 32'(vecs[i].exp_byte));
      end

      // Glitch: four low samples, then high.
      k = cyc + 1;
      set_line(0, 1'b0);
      wait_cycle(k + 2);
      check("glitch_busy_pre", 32'(if16.busy), 0);
      wait_cycle(k + 3);
      check("glitch_busy_rise", 32'(if16.busy), 1);
      @(posedge clk);
      #1 set_line(0, 1'b1);
      wait_cycle(k + 2 + C16 / 2);
      check("glitch_busy_mid", 32'(if16.busy), 1);
      wait_cycle(k + 3 + C16 / 2);
      check("glitch_busy_fall", 32'(if16.busy), 0);
      @(posedge clk);
      #1;
      settle(0);
      expect_quiet(0, "glitch_no_pulse");

      // Framing error followed by a 40-cycle break, then recovery.
      send_frame(0, 8'h55, 1'b0, k);
      hold(0, 1'b0, 40);
      check("break_busy", 32'(if16.busy), 1);
      settle(0);
      check("break_idle", 32'(if16.busy), 0);
      expect_ev(0, "ferr", pulse_at(0, k), 1'b0, 8'h00);
      expect_quiet(0, "ferr_single");
      check("ferr_byte_kept", 32'(if16.rx_byte), 32'h80);
      send_frame(0, 8'h5A, 1'b1, k);
      settle(0);
      expect_ev(0, "after_ferr", pulse_at(0, k), 1'b1, 8'h5A);

      // Reset in the middle of data bit 3 of 0xFF.
      hold(0, 1'b0, C16);
      for (int i = 0; i < 3; i++) hold(0, 1'b1, C16);
      hold(0, 1'b1, C16 / 2);
      rst_n = 1'b0;
      #1;
      check("mrst_byte",  32'(if16.rx_byte), 0);
      check("mrst_valid", 32'(if16.rx_valid), 0);
      check("mrst_err",   32'(if16.frame_err), 0);
      check("mrst_busy",  32'(if16.busy), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      settle(0);
      expect_quiet(0, "mrst_no_pulse");
      send_frame(0, 8'hA5, 1'b1, k);
      settle(0);
      expect_ev(0, "after_rst", pulse_at(0, k), 1'b1, 8'hA5);

      // Odd divisor instance.
      expect_quiet(1, "c5_silent");
      send_frame(1, 8'hC3, 1'b1, k);
      settle(1);
      check("c5_formula", pulse_at(1, k) - k, 50);
      expect_ev(1, "c5_c3", pulse_at(1, k), 1'b1, 8'hC3);

      // Random bytes with random idle gaps on both instances.
      for (int s = 0; s < 2; s++) begin
         bit sel;
         sel = bit'(s);
         pend.delete();
         for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            int         gap;
            d   = 8'($urandom_range(0, 255));
            gap = int'($urandom_range(0, 3 * cpb(sel)));
            if (gap > 0) hold(sel, 1'b1, gap);
            send_frame(sel, d, 1'b1, k);
            pend.push_back('{pulse_at(sel, k), d});
         end
         settle(sel);
         foreach (pend[i])
            expect_ev(sel, $sformatf("rnd%0d_%0d", s, i), pend[i].cyc, 1'b1, pend[i].d);
         expect_quiet(sel, $sformatf("rnd%0d_no_extra", s));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
